// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port 32-bit data memory with a fixed number of wait states.
//   One request is accepted in IDLE. The FSM then spends WAIT_CYCLES cycles
//   in WAIT, followed by one cycle in RESP, and returns to IDLE. Requests
//   that arrive while Busy is high are ignored.
//
// Parameters
//   ADDR_BITS   word-index width; the memory holds 2**ADDR_BITS words
//   WAIT_CYCLES number of wait-state cycles before each response (0..15)
//
// Ports
//   CLK        sole clock, rising edge
//   Reset      synchronous active-high reset (memory contents are kept)
//   MemRead    load request (sampled in IDLE)
//   MemWrite   store request (sampled in IDLE; wins over MemRead)
//   Addr       byte address; word index is Addr[ADDR_BITS+1:2]
//   WriteData  store data
//   ReadData   registered load data; holds until the next load response
//   Ready      one-cycle response strobe (state RESP)
//   Busy       high while a request is in flight (WAIT or RESP)
//   AddrErr    misaligned-access flag, valid with Ready
//
// Build option
//   MEM_MISALIGN_CHECK_EN  when defined, a latched Addr[1:0] != 0 raises
//                          AddrErr, suppresses the store, and returns 0 for
//                          a load. When undefined, Addr[1:0] is ignored and
//                          AddrErr is tied low.
module data_mem_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int         DEPTH     = 2 ** ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]           cnt;
  logic                 op_wr;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          wdata;
  logic [31:0]          mem [DEPTH];

  logic                 req;
  logic                 accept;
  logic                 enter_resp;
  logic                 eff_wr;
  logic [ADDR_BITS-1:0] eff_idx;
  logic [31:0]          eff_wdata;
  logic                 eff_mis;

  assign req    = MemRead | MemWrite;
  assign accept = (state == ST_IDLE) && req;

  // With WAIT_CYCLES == 0 the acceptance edge is also the edge that enters
  // RESP. The commit therefore has to use the live inputs while in IDLE.
  // In every other case the latched request is used.
  assign eff_wr    = (state == ST_IDLE) ? MemWrite : op_wr;
  assign eff_idx   = (state == ST_IDLE) ? Addr[ADDR_BITS+1:2] : idx;
  assign eff_wdata = (state == ST_IDLE) ? WriteData : wdata;

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis;
  logic unused_addr;

  assign eff_mis     = (state == ST_IDLE) ? (Addr[1:0] != 2'b00) : mis;
  assign unused_addr = ^Addr[31:ADDR_BITS+2];

  always_ff @(posedge CLK) begin
    if (accept) mis <= (Addr[1:0] != 2'b00);
  end
`else
  logic unused_addr;

  assign eff_mis     = 1'b0;
  assign unused_addr = ^{Addr[31:ADDR_BITS+2], Addr[1:0]};
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_next == ST_RESP) && !Reset;

  // Output logic
  always_comb begin
    Busy  = (state == ST_WAIT) || (state == ST_RESP);
    Ready = (state == ST_RESP);
`ifdef MEM_MISALIGN_CHECK_EN
    AddrErr = (state == ST_RESP) && mis;
`else
    AddrErr = 1'b0;
`endif
  end

  // Request latch: these are data registers and are not reset
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_wr <= MemWrite;
      idx   <= Addr[ADDR_BITS+1:2];
      wdata <= WriteData;
    end
  end

  // Memory array. Reset does not touch it, and a Reset on the commit edge
  // blocks the store.
  always_ff @(posedge CLK) begin
    if (enter_resp && eff_wr && !eff_mis) mem[eff_idx] <= eff_wdata;
  end

  // Wait counter and load data
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt      <= 4'd0;
      ReadData <= 32'd0;
    end else begin
      if (accept)                                cnt <= WAIT_LOAD;
      else if (state == ST_WAIT && cnt != 4'd0)  cnt <= cnt - 4'd1;
      if (enter_resp && !eff_wr) ReadData <= eff_mis ? 32'd0 : mem[eff_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int AB    = 6;
  localparam int W     = 2;
  localparam int DEPTH = 2 ** AB;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        AddrErr;

  int total = 0;
  int bad   = 0;

  // Reference model: a word-indexed array of known contents plus the value
  // ReadData is expected to hold.
  logic [31:0] model_mem [int];
  logic [31:0] exp_rd;
  bit          rd_known;

  data_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Ready    (Ready),
    .Busy     (Busy),
    .AddrErr  (AddrErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Issues one request and checks every cycle until the FSM is back in IDLE.
  // When noisy is set, random request pulses are driven while Busy is high.
  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d, input bit noisy);
    int  w;
    bit  m;
    bit  is_wr;
    w     = word_of(a);
    m     = misaligned(a);
    is_wr = wr;
    @(negedge CLK);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
    @(posedge CLK);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      check({tag, " busy"}, 32'(Busy), 32'd1);
      check({tag, " ready"}, 32'(Ready), (c == W + 1) ? 32'd1 : 32'd0);
      if (c == W + 1) begin
        check({tag, " addrerr"}, 32'(AddrErr), 32'(m));
        if (is_wr) begin
          if (!m) model_mem[w] = d;
        end else begin
          if (m) begin
            exp_rd = 32'd0; rd_known = 1'b1;
          end else if (model_mem.exists(w)) begin
            exp_rd = model_mem[w]; rd_known = 1'b1;
          end else begin
            rd_known = 1'b0;
          end
        end
        if (rd_known) check({tag, " rdata"}, ReadData, exp_rd);
      end
      if (noisy) begin
        MemRead   = 1'($urandom_range(0, 1));
        MemWrite  = 1'($urandom_range(0, 1));
        Addr      = $urandom();
        WriteData = $urandom();
      end
      @(posedge CLK);
      #1;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    check({tag, " idle busy"}, 32'(Busy), 32'd0);
    check({tag, " idle ready"}, 32'(Ready), 32'd0);
    if (rd_known) check({tag, " rdata hold"}, ReadData, exp_rd);
  endtask

  initial begin
    logic [31:0] a;
    int          wi;
    Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0;
    exp_rd = 32'd0; rd_known = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset rdata", ReadData, 32'd0);
    check("reset ready", 32'(Ready), 32'd0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset addrerr", 32'(AddrErr), 32'd0);
    Reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check("idle rdata", ReadData, 32'd0);
      check("idle ready", 32'(Ready), 32'd0);
      check("idle busy", 32'(Busy), 32'd0);
    end

    // Basic write then read-back, including read-after-write
    txn("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Aliasing across the upper address bits
    txn("wr104", 1'b0, 1'b1, 32'h104, 32'h12345678, 1'b0);
    txn("rd004", 1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
    check("alias value", exp_rd, 32'h12345678);

    // Both strobes high count as a write; pulses during Busy are ignored
    txn("both20", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b1);
    txn("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    check("both value", exp_rd, 32'hA5A5A5A5);

    // Reset on the commit edge abandons the pending write
    txn("wr30a", 1'b0, 1'b1, 32'h30, 32'h11111111, 1'b0);
    @(negedge CLK);
    MemRead = 1'b0; MemWrite = 1'b1; Addr = 32'h30; WriteData = 32'h22222222;
    if (W == 0) Reset = 1'b1;
    @(posedge CLK);
    #1;
    MemWrite = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) Reset = 1'b1;
      @(posedge CLK);
      #1;
    end
    check("abort busy", 32'(Busy), 32'd0);
    check("abort ready", 32'(Ready), 32'd0);
    check("abort rdata", ReadData, 32'd0);
    check("abort addrerr", 32'(AddrErr), 32'd0);
    Reset = 1'b0;
    exp_rd = 32'd0; rd_known = 1'b1;
    txn("rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
    check("abort value", exp_rd, 32'h11111111);

    // Misaligned store and load
    txn("wr31", 1'b0, 1'b1, 32'h31, 32'hCAFEF00D, 1'b0);
    txn("rd30m", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0);
`ifdef MEM_MISALIGN_CHECK_EN
    check("misalign kept", exp_rd, 32'h11111111);
`else
    check("misalign wrote", exp_rd, 32'hCAFEF00D);
`endif
    txn("rd33", 1'b1, 1'b0, 32'h33, 32'h0, 1'b0);

    // Prefill a small pool of words, then run random traffic over it
    for (int i = 0; i < 8; i++)
      txn("fill", 1'b0, 1'b1, 32'(i * 4), $urandom(), 1'b0);
    for (int n = 0; n < 40; n++) begin
      wi = $urandom_range(0, 7);
      a  = ($urandom() & ~(32'(DEPTH - 1) << 2)) | (32'(wi) << 2);
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      case ($urandom_range(0, 2))
        0:       txn("rnd wr", 1'b0, 1'b1, a, $urandom(), 1'($urandom_range(0, 1)));
        1:       txn("rnd rd", 1'b1, 1'b0, a, $urandom(), 1'($urandom_range(0, 1)));
        default: txn("rnd both", 1'b1, 1'b1, a, $urandom(), 1'($urandom_range(0, 1)));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
